// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, issues word requests to
// instruction memory and holds each returned instruction until decode takes it.
module fetch_unit #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [1:0]      PCSrc,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            inst_valid,
   output logic [31:0]     inst_out,
   output logic [XLEN-1:0] pc_out,
   input  logic            inst_ready,
   output logic            misalign_err
);

   localparam logic [1:0] PC_IMM     = 2'b01;
   localparam logic [1:0] PC_REG_IMM = 2'b10;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_FETCH     = 2'd1;
   localparam logic [1:0] S_WAIT_RESP = 2'd2;
   localparam logic [1:0] S_HOLD      = 2'd3;

   localparam logic [XLEN-1:0] BIT0 = XLEN'(1);
   localparam logic [XLEN-1:0] STEP = XLEN'(4);

   logic [1:0]      state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            drop, drop_nxt;
   logic            capture;
   logic            redirect;
   logic [XLEN-1:0] target_raw, target_pc;

   // PC_4 and the reserved 2'b11 encoding both leave the fetch stream alone.
   assign redirect   = redirect_valid && (PCSrc == PC_IMM || PCSrc == PC_REG_IMM);
   assign target_raw = (PCSrc == PC_REG_IMM) ? ((rs1 + imm) & ~BIT0)
                                             : (redirect_pc + imm);
   assign target_pc  = target_raw[1] ? {target_raw[XLEN-1:2], 2'b00} : target_raw;

   assign imem_req   = (state == S_FETCH);
   assign imem_addr  = pc;
   assign inst_valid = (state == S_HOLD);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      drop_nxt  = drop;
      capture   = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               state_nxt = S_WAIT_RESP;
               // A request accepted alongside a redirect fetched the old PC.
               drop_nxt  = redirect;
            end
         end
         S_WAIT_RESP: begin
            if (imem_rvalid) begin
               drop_nxt = 1'b0;
               if (drop || redirect) begin
                  state_nxt = S_FETCH;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if (redirect) begin
               drop_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               state_nxt = S_FETCH;
            end else if (inst_ready) begin
               state_nxt = S_FETCH;
               pc_nxt    = pc + STEP;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (redirect) pc_nxt = target_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pc           <= RESET_PC;
         drop         <= 1'b0;
         inst_out     <= '0;
         pc_out       <= '0;
         misalign_err <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         drop  <= drop_nxt;
         if (capture) begin
            inst_out <= imem_rdata;
            pc_out   <= pc;
         end
         if (redirect && target_raw[1]) misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random memory/decode/redirect
// traffic against a transaction-level model of the PC and delivered instructions.
module tb_fetch_unit;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk, rst_n;
   logic        redirect_valid;
   logic [1:0]  PCSrc;
   logic [31:0] redirect_pc, imm, rs1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out, pc_out;
   logic        inst_ready;
   logic        misalign_err;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .PCSrc(PCSrc),
      .redirect_pc(redirect_pc), .imm(imm), .rs1(rs1),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out),
      .inst_ready(inst_ready), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: architectural PC, outstanding request, held instruction, sticky error.
   logic [31:0] m_pc;
   logic        m_idle, m_pend, m_stale, m_valid, m_err;
   logic [31:0] m_pend_addr, m_hold_pc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_idle = 1'b1; m_pend = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_pend_addr = '0; m_hold_pc = '0;
   endtask

   // One cycle: check outputs at the negedge, drive inputs, advance the model
   // across the coming posedge, then wait for the next negedge.
   task automatic step(input logic rdy, input logic rv, input logic rdr,
                       input logic [1:0] src, input logic [31:0] rpc,
                       input logic [31:0] im, input logic [31:0] r1, input logic ir);
      logic        exp_req, act, nvalid;
      logic [31:0] t;
      exp_req = !m_idle && !m_pend && !m_valid;
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", inst_valid, m_valid);
      if (m_valid) begin
         chk("pc_out", pc_out, m_hold_pc);
         chk("inst_out", inst_out, memword(m_hold_pc));
      end
      chk("misalign_err", misalign_err, m_err);

      imem_ready = rdy; imem_rvalid = rv;
      imem_rdata = (rv && m_pend) ? memword(m_pend_addr) : $urandom;
      redirect_valid = rdr; PCSrc = src; redirect_pc = rpc; imm = im; rs1 = r1;
      inst_ready = ir;

      act    = rdr && (src == 2'b01 || src == 2'b10);
      nvalid = m_valid && !act && !ir;
      if (m_pend && rv) begin
         if (!m_stale && !act) begin
            nvalid    = 1'b1;
            m_hold_pc = m_pend_addr;
         end
         m_pend = 1'b0;
      end else if (m_pend && act) begin
         m_stale = 1'b1;
      end
      if (exp_req && rdy) begin
         m_pend = 1'b1; m_pend_addr = m_pc; m_stale = act;
      end
      if (act) begin
         t = (src == 2'b10) ? ((r1 + im) & 32'hFFFF_FFFE) : (rpc + im);
         if (t[1]) begin
            m_err = 1'b1;
            t     = t & 32'hFFFF_FFFC;
         end
         m_pc = t;
      end else if (m_valid && ir) begin
         m_pc = m_pc + 32'd4;
      end
      m_valid = nvalid;
      m_idle  = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_misalign", misalign_err, 1'b0);
      chk("rst_addr", imem_addr, RESET_PC);
      imem_ready = 0; imem_rvalid = 0; redirect_valid = 0; inst_ready = 0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] b;
      int n;
      rst_n = 1'b1;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = '0; redirect_valid = 0;
      PCSrc = 2'b00; redirect_pc = '0; imm = '0; rs1 = '0; inst_ready = 0;
      model_reset();
      do_reset();

      // Zero-wait memory, always-ready decode: fetches at 0x0, 0x4, 0x8.
      for (int i = 0; i < 9; i++) step(1, 1, 0, 2'b00, '0, '0, '0, 1);
      chk("third_hold_pc", pc_out, 32'h8);

      // Decode stall for five cycles while in HOLD.
      for (int i = 0; i < 5; i++) step(1, 1, 0, 2'b00, '0, '0, '0, 0);
      chk("stall_pc_out", pc_out, 32'h8);
      step(1, 1, 0, 2'b00, '0, '0, '0, 1);

      // PC_imm redirect while waiting for a response: late data dropped.
      step(1, 0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 1, 2'b01, 32'h100, 32'h20, '0, 1);
      step(0, 1, 0, 2'b00, '0, '0, '0, 1);
      chk("redir_wait_addr", imem_addr, 32'h120);

      // JALR to a misaligned target.
      step(0, 0, 1, 2'b10, '0, 32'h0, 32'h203, 1);
      chk("misalign_set", misalign_err, 1'b1);
      chk("misalign_addr", imem_addr, 32'h200);

      // Redirect coinciding with decode accept in HOLD.
      step(1, 0, 0, 2'b00, '0, '0, '0, 0);
      step(0, 1, 0, 2'b00, '0, '0, '0, 0);
      step(0, 0, 1, 2'b01, 32'h400, 32'hFFFF_FFFC, '0, 1);
      chk("hold_redir_addr", imem_addr, 32'h3FC);
      chk("hold_redir_valid", inst_valid, 1'b0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         b = 8'($urandom);
         step(1'($urandom), m_pend && 1'($urandom), ($urandom % 6) == 0,
              2'($urandom), $urandom & 32'h0000_FFFF, {{24{b[7]}}, b},
              $urandom & 32'h0000_FFFF, ($urandom % 4) != 0);
      end

      // Reset mid-transaction, then a stray response in IDLE/FETCH.
      n = 0;
      while (!m_pend && n < 20) begin
         step(1, 0, 0, 2'b00, '0, '0, '0, 1);
         n++;
      end
      chk("reach_wait", m_pend, 1'b1);
      do_reset();
      step(0, 1, 0, 2'b00, '0, '0, '0, 1);
      chk("first_req_addr", imem_addr, RESET_PC);
      step(0, 1, 0, 2'b00, '0, '0, '0, 1);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 2'b00, '0, '0, '0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural PC and consumes the 2-bit `PCSrc` produced by the branch/jump decision logic. It issues word requests to instruction memory over a req/ready + rvalid handshake, holds the returned instruction for decode until accepted, and applies redirects (JAL, branches, JALR) by discarding in-flight or held instructions. It sits between the execute-stage PC-select logic (upstream decision) and the decode stage.

## Interface
- `XLEN`, 32, datapath and address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `redirect_valid` in 1 — execute stage presents a resolved control-flow instruction this cycle
- `PCSrc` in 2 — `PC_4`=2'b00, `PC_imm`=2'b01, `PC_reg_imm`=2'b10 (constants.vh); 2'b11 treated as `PC_4`
- `redirect_pc` in XLEN — PC of the control-flow instruction
- `imm` in XLEN — sign-extended immediate
- `rs1` in XLEN — rs1 operand for JALR
- `imem_req` out 1 — fetch request
- `imem_addr` out XLEN — fetch address (= current PC)
- `imem_ready` in 1 — memory accepts request this cycle
- `imem_rvalid` in 1 — response data valid
- `imem_rdata` in 32 — instruction word
- `inst_valid` out 1 — instruction available to decode
- `inst_out` out 32 — held instruction
- `pc_out` out XLEN — PC of `inst_out`
- `inst_ready` in 1 — decode accepts instruction
- `misalign_err` out 1 — sticky: a redirect target had bit 1 set

## Operation
- States: IDLE, FETCH, WAIT_RESP, HOLD. Internal `drop` flag.
- IDLE → FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ready` → WAIT_RESP.
- WAIT_RESP: on `imem_rvalid`: if `drop`, clear it → FETCH; else latch `imem_rdata`→`inst_out`, pc→`pc_out`, set `inst_valid` → HOLD.
- HOLD: `inst_valid`=1, outputs stable. On `inst_ready`: pc ← pc+4, clear `inst_valid` → FETCH.
- Redirect is active when `redirect_valid` and `PCSrc` ∈ {`PC_imm`, `PC_reg_imm`}; `PC_4`/2'b11 redirects are no-ops.
- Target: `PC_imm` → `redirect_pc + imm`; `PC_reg_imm` → `(rs1 + imm) & ~1`. Sums modulo 2^XLEN.
- If target[1]=1: set `misalign_err` (cleared only by reset), load pc with target[1:0] forced to 00.
- Redirect actions (priority over every other event):
  - pc ← target; `inst_valid` cleared next edge.
  - FETCH without `imem_ready`: stay FETCH, new address next cycle.
  - FETCH with `imem_ready` same cycle: stale request accepted → WAIT_RESP with `drop`=1.
  - WAIT_RESP without `imem_rvalid`: set `drop`, stay.
  - WAIT_RESP with `imem_rvalid` same cycle: discard response → FETCH, `drop`=0.
  - HOLD: held instruction discarded even if `inst_ready`=1 → FETCH; pc is not incremented.
- `imem_addr` may change while `imem_req` is high without `imem_ready`; memory samples only on req&&ready.

## Timing
- Reset values: state IDLE, pc=`RESET_PC`, `imem_req`=0, `inst_valid`=0, `inst_out`=0, `pc_out`=0, `misalign_err`=0, `drop`=0.
- Reset is asynchronous; assertion mid-transaction aborts immediately. Memory responses arriving after reset and before the first new request are ignored (IDLE/FETCH ignore `imem_rvalid`).
- First `imem_req` is asserted in the 2nd rising edge after `rst_n` deasserts, i.e. one IDLE cycle.
- `imem_ready` at edge N, `imem_rvalid` at edge M≥N+1 → `inst_valid` high after edge M.
- Back-to-back throughput: one instruction per 3 cycles with zero-wait memory and always-ready decode.
- All outputs are registered or decoded from state only; there is no combinational input→output path.

## Test plan
- Reset release, zero-wait memory, `inst_ready`=1 → requests at 0x0, 0x4, 0x8; `pc_out` matches; `misalign_err`=0.
- HOLD with `inst_ready`=0 for 5 cycles → `inst_out`/`pc_out` stable, no new `imem_req`.
- In WAIT_RESP, redirect `PC_imm` with `redirect_pc`=0x100, `imm`=0x20 → late response dropped; next request at 0x120.
- Redirect `PC_reg_imm`, `rs1`=0x203, `imm`=0 → target 0x202, `misalign_err`=1, fetch at 0x200.
- Redirect and `inst_ready` in the same HOLD cycle → instruction discarded; next fetch at target, not pc+4.
- `rst_n` low while in WAIT_RESP, then `imem_rvalid` arrives in IDLE → ignored; first fetch at `RESET_PC`.
